irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt controller in front of the pipelined core's CSR register file. Synchronises
//  NUM_SRC external request lines and latches them as pending bits. Selects one by fixed
//  priority, drives its code onto the core's 2-bit interrupt input, waits for the trap to be
//  taken (epc_taken), then for the handler to return (mret). Guarantees one interrupt in
//  flight at a time and a minimum drain gap between interrupts.
// PARAMETERS
//  NUM_SRC  3  number of request sources; codes 1..NUM_SRC, code 0 = no interrupt (max 3)
//  GAP      4  idle cycles enforced after mret before the next request is issued (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state
//  irq_src    in   NUM_SRC  raw request lines, asynchronous to clk
//  edge_mode  in   NUM_SRC  per source: 1 = rising-edge latched, 0 = level
//  irq_en     in   NUM_SRC  per-source enable mask; quasi-static
//  epc_taken  in   1        core has redirected PC to the trap vector (ack)
//  is_mret    in   1        mret retired in MW stage (handler complete)
//  interrupt  out  2        code to core: 0 none, else 1-based source index
//  busy       out  1        1 when state != IDLE
//  pending    out  NUM_SRC  current pending vector, before masking
// BEHAVIOUR
//  Reset: interrupt=0, busy=0, pending=0, sync flops=0, state=IDLE, gap counter=0.
//  Input path: 2-flop synchroniser per source, plus a third flop for edge detect.
//   A raw change reaches pending no earlier than 2 cycles after it is sampled.
//  Pending, edge source: set on synced 0->1. Cleared only when that source is acked.
//   If a set and a clear coincide, set wins, so the new edge is kept.
//  Pending, level source: pending[i] = synced level. Never cleared by ack.
//  Eligible = pending & irq_en. Winner = lowest index eligible; code = index+1.
//  FSM:
//   IDLE: interrupt=0. If gap counter==0 and eligible!=0, latch winner code and go to REQ.
//   REQ: interrupt=latched code, held stable even if the source drops or is masked.
//    On epc_taken: clear the edge pending bit of the latched source, set interrupt=0
//    next cycle, and go to SERVICE.
//    is_mret in REQ is ignored.
//   SERVICE: interrupt=0. New requests only accumulate as pending.
//    On is_mret: load gap counter with GAP and go to IDLE.
//  Gap counter: decrements by 1 per cycle in IDLE while nonzero, saturating at 0.
//   Earliest next interrupt is GAP+1 cycles after the is_mret cycle.
//  Registered outputs: interrupt changes only on clk edges, never combinationally from inputs.
//  epc_taken in IDLE or SERVICE is ignored. Simultaneous epc_taken and is_mret in REQ: take
//   the ack only; the mret is dropped.
//  Masking a source while it is latched in REQ does not withdraw the request.
//  Reset asserted mid-operation: immediate return to reset values, with no ack or mret side
//   effects. All pending bits are lost.
// TESTING
//  1 Reset: reset=1 with irq_src toggling -> interrupt=0, busy=0, pending=0 throughout.
//  2 Single edge: edge_mode=3'b001, irq_en=3'b111, pulse irq_src[0] for 1 cycle
//    -> pending[0]=1 within 3 cycles; interrupt=1 the next cycle; stays 1 until epc_taken;
//       0 one cycle after epc_taken; busy stays 1 until is_mret.
//  3 Priority: sources 2 and 1 (edge) rise in the same cycle -> interrupt=2'd2 (source 1)
//    first. After mret plus GAP=4 idle cycles -> interrupt=2'd3.
//  4 Mask: irq_en=3'b011 and source 2 pending -> interrupt stays 0. Set irq_en[2]=1
//    -> interrupt=3 within 1 cycle (IDLE, gap=0).
//  5 Level source: edge_mode=0, irq_src[1] held high through ack and mret -> the same
//    interrupt=2 is reissued exactly GAP+1 cycles after is_mret.
//  6 Corner cases: a new edge on source 0 in the same cycle as its ack -> pending[0] stays 1.
//    Reset pulsed in SERVICE -> IDLE with pending=0, and no interrupt after release.

Source files
------------

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: synchronises request lines, latches pending bits and issues one
// fixed-priority interrupt code at a time, with a drain gap after each handler return.
module irq_sequencer_lane (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic [2:0] s_q, s_d;
  logic       pend_q, pend_d;
  logic       rise;

  // s_q[1] is the synchronised level; s_q[2] is its previous value for edge detection
  always_comb begin
    s_d    = {s_q[1:0], raw};
    rise   = s_q[1] & ~s_q[2];
    pend_d = edge_mode ? ((pend_q & ~clr) | rise) : s_q[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

module irq_sequencer #(
  parameter int NUM_SRC = 3,
  parameter int GAP     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               epc_taken,
  input  logic               is_mret,
  output logic [1:0]         interrupt,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending
);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         code_q, code_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [1:0]         interrupt_q, interrupt_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] pend, elig, clr;
  logic [1:0]         win_code;
  logic               ack;

  assign ack = (state_q == REQ) && epc_taken;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign clr[i] = ack && (code_q == 2'(i + 1));
    irq_sequencer_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .raw       (irq_src[i]),
      .edge_mode (edge_mode[i]),
      .clr       (clr[i]),
      .pend      (pend[i])
    );
  end

  assign elig = pend & irq_en;

  always_comb begin
    win_code = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win_code = 2'(i + 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= 2'd0;
      gap_q       <= '0;
      interrupt_q <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      gap_q       <= gap_d;
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
    end
  end

  // next state; an mret coinciding with the ack in REQ is deliberately dropped
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        else if (win_code != 2'd0) begin
          code_d  = win_code;
          state_d = REQ;
        end
      end
      REQ:     if (epc_taken) state_d = SERVICE;
      SERVICE: if (is_mret) begin
        gap_d   = GW'(GAP);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are precomputed from the next state so the core sees flop outputs only
  always_comb begin
    interrupt_d = (state_d == REQ) ? code_d : 2'd0;
    busy_d      = (state_d != IDLE);
  end

  assign interrupt = interrupt_q;
  assign busy      = busy_q;
  assign pending   = pend;
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: reset, edge/level latching, priority, masking, gap timing.
module tb_irq_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] irq_src = '0, edge_mode = '0, irq_en = '0;
  logic       epc_taken = 1'b0, is_mret = 1'b0;
  logic [1:0] interrupt;
  logic       busy;
  logic [2:0] pending;
  int checks = 0, errors = 0;

  irq_sequencer #(.NUM_SRC(3), .GAP(4)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .edge_mode(edge_mode), .irq_en(irq_en),
    .epc_taken(epc_taken), .is_mret(is_mret), .interrupt(interrupt), .busy(busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] irq, input logic bsy,
                         input logic [2:0] pnd);
    chk({tag, ".interrupt"}, 8'(interrupt), 8'(irq));
    chk({tag, ".busy"}, 8'(busy), 8'(bsy));
    chk({tag, ".pending"}, 8'(pending), 8'(pnd));
  endtask

  initial begin
    // 1 reset held while requests toggle
    #2 reset = 1'b1;
    edge_mode = 3'b000; irq_en = 3'b111;
    for (int i = 0; i < 4; i++) begin
      irq_src = (i % 2 == 0) ? 3'b111 : 3'b000;
      tick();
      chk_out("reset", 2'd0, 1'b0, 3'b000);
    end
    irq_src = '0;
    reset = 1'b0;
    tick(3);
    chk_out("post_reset", 2'd0, 1'b0, 3'b000);

    // 2 single edge on source 0
    edge_mode = 3'b001; irq_en = 3'b111;
    irq_src = 3'b001; tick(); irq_src = '0;
    tick();
    chk_out("edge_sync1", 2'd0, 1'b0, 3'b000);
    tick();
    chk_out("edge_pend", 2'd0, 1'b0, 3'b001);
    tick();
    chk_out("edge_req", 2'd1, 1'b1, 3'b001);
    tick(2);
    chk_out("edge_hold", 2'd1, 1'b1, 3'b001);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    chk_out("edge_ack", 2'd0, 1'b1, 3'b000);
    tick(2);
    chk_out("edge_service", 2'd0, 1'b1, 3'b000);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    chk_out("edge_mret", 2'd0, 1'b0, 3'b000);
    tick(6);

    // 3 priority: sources 1 and 2 together, then gap before source 2
    edge_mode = 3'b111;
    irq_src = 3'b110; tick(); irq_src = '0;
    tick(2);
    chk_out("prio_pend", 2'd0, 1'b0, 3'b110);
    tick();
    chk_out("prio_first", 2'd2, 1'b1, 3'b110);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    chk_out("prio_ack", 2'd0, 1'b1, 3'b100);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    tick(4);
    chk_out("prio_gap", 2'd0, 1'b0, 3'b100);
    tick();
    chk_out("prio_second", 2'd3, 1'b1, 3'b100);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    tick(6);
    chk_out("prio_done", 2'd0, 1'b0, 3'b000);

    // 4 masking, then unmask in IDLE and mask again while in REQ
    irq_en = 3'b011;
    irq_src = 3'b100; tick(); irq_src = '0;
    tick(5);
    chk_out("mask_block", 2'd0, 1'b0, 3'b100);
    irq_en = 3'b111; tick();
    chk_out("mask_release", 2'd3, 1'b1, 3'b100);
    irq_en = 3'b011; tick(2);
    chk_out("mask_in_req", 2'd3, 1'b1, 3'b100);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    irq_en = 3'b111;
    tick(6);

    // 5 level source held: mret in REQ ignored, ack+mret drops mret, reissue after gap
    edge_mode = 3'b000;
    irq_src = 3'b010;
    tick(3);
    chk_out("lvl_pend", 2'd0, 1'b0, 3'b010);
    tick();
    chk_out("lvl_req", 2'd2, 1'b1, 3'b010);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    chk_out("lvl_mret_in_req", 2'd2, 1'b1, 3'b010);
    epc_taken = 1'b1; is_mret = 1'b1; tick(); epc_taken = 1'b0; is_mret = 1'b0;
    chk_out("lvl_ack_mret", 2'd0, 1'b1, 3'b010);
    tick();
    chk_out("lvl_service", 2'd0, 1'b1, 3'b010);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    chk_out("lvl_mret", 2'd0, 1'b0, 3'b010);
    tick(4);
    chk_out("lvl_gap", 2'd0, 1'b0, 3'b010);
    tick();
    chk_out("lvl_reissue", 2'd2, 1'b1, 3'b010);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    irq_src = '0;
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    tick(8);
    chk_out("lvl_dropped", 2'd0, 1'b0, 3'b000);

    // 6a new edge on source 0 coinciding with its ack keeps pending
    edge_mode = 3'b001;
    irq_src = 3'b001; tick(); irq_src = '0;
    tick(3);
    chk_out("race_req", 2'd1, 1'b1, 3'b001);
    irq_src = 3'b001; tick(2);
    epc_taken = 1'b1; tick(); epc_taken = 1'b0;
    chk_out("race_set_wins", 2'd0, 1'b1, 3'b001);
    irq_src = '0;
    tick();

    // 6b reset pulsed in SERVICE discards everything
    reset = 1'b1; #1;
    chk_out("rst_async", 2'd0, 1'b0, 3'b000);
    tick();
    reset = 1'b0;
    tick(8);
    chk_out("rst_after", 2'd0, 1'b0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
